// File: rtl/dct2_1d_seq_pkg.sv
// Shared types and coefficient helpers for the folded 1-D DCT-II engine.
// C64 is the signed 8-bit 64-point DCT-II matrix, generated from its first column.
package dct2_pkg;

  typedef enum logic [1:0] {SZ4 = 2'd0, SZ8 = 2'd1, SZ16 = 2'd2, SZ32 = 2'd3} size_e;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CALC = 2'd1, ST_DONE = 2'd2} state_e;

  // First column of C64: C64[k][0] for k = 0..63.
  localparam logic signed [7:0] C64_COL0 [64] = '{
    64, 91, 90, 90, 90, 90, 90, 90, 89, 88, 88, 87, 87, 86, 85, 84,
    83, 83, 82, 81, 80, 79, 78, 77, 75, 73, 73, 71, 70, 69, 67, 65,
    64, 62, 61, 59, 57, 56, 54, 52, 50, 48, 46, 44, 43, 41, 38, 37,
    36, 33, 31, 28, 25, 24, 22, 20, 18, 15, 13, 11,  9,  7,  4,  2
  };

  function automatic int size_of(size_e s);
    case (s)
      SZ4:     return 4;
      SZ8:     return 8;
      SZ16:    return 16;
      default: return 32;
    endcase
  endfunction

  // Every non-DC entry is +/- a first-column value selected by the phase (2n+1)k mod 256.
  function automatic logic signed [7:0] c64(int k, int n);
    int a;
    if (k == 0) return C64_COL0[0];
    a = ((2 * n + 1) * k) % 256;
    if (a < 64)       return C64_COL0[6'(a)];
    else if (a < 128) return -C64_COL0[6'(128 - a)];
    else if (a < 192) return -C64_COL0[6'(a - 128)];
    else              return C64_COL0[6'(256 - a)];
  endfunction

  function automatic logic signed [7:0] coef(size_e s, int k, int n);
    return c64(k * (64 / size_of(s)), n);
  endfunction

endpackage

// File: rtl/dct2_1d_seq_if.sv
// Vector-in / vector-out bus between the residual buffer, the DCT engine and the transpose memory.
// Handshake: a transfer happens on the rising clk edge where valid && ready; the sender holds
// valid and its payload steady until that edge, and ready may not depend on valid.
interface dct2_1d_seq_if #(
  parameter int MAX_N = 32,
  parameter int IN_W  = 16,
  parameter int OUT_W = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [1:0]             N;
  logic [4:0]             shift;
  logic [MAX_N*IN_W-1:0]  X;
  logic                   out_valid;
  logic                   out_ready;
  logic [MAX_N*OUT_W-1:0] Y;

  modport master (
    output in_valid, N, shift, X, out_ready,
    input  in_ready, out_valid, Y
  );

  modport slave (
    input  in_valid, N, shift, X, out_ready,
    output in_ready, out_valid, Y
  );
endinterface

// File: rtl/dct2_1d_seq_lane.sv
// One output row: full-precision dot product of a coefficient row with the samples,
// followed by round-half-up right shift and saturation to OUT_W.
module dct2_lane
  import dct2_pkg::*;
#(
  parameter int MAX_N = 32,
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int ACC_W = IN_W + 8 + $clog2(MAX_N) + 1
) (
  input  size_e                   size,
  input  logic [5:0]              k,
  input  logic [4:0]              shift,
  input  logic [MAX_N*IN_W-1:0]   x,
  output logic signed [OUT_W-1:0] y
);

  // Wide enough for the rounding constant at shift=31 on top of the full sum.
  localparam int RND_W = ((ACC_W > 32) ? ACC_W : 32) + 1;
  localparam logic signed [RND_W-1:0] Y_MAX = RND_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [RND_W-1:0] Y_MIN = ~Y_MAX;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod;
  logic signed [RND_W-1:0] rnd;
  logic signed [IN_W-1:0]  xn;
  logic signed [7:0]       c;

  always_comb begin
    acc  = '0;
    prod = '0;
    xn   = '0;
    c    = '0;
    for (int n = 0; n < MAX_N; n++) begin
      xn   = x[n*IN_W +: IN_W];
      c    = (n < size_of(size)) ? coef(size, int'(k), n) : 8'sd0;
      prod = ACC_W'(c) * ACC_W'(xn);
      acc  = acc + prod;
    end
    rnd = RND_W'(acc);
    if (shift != 5'd0) begin
      rnd = (rnd + (RND_W'(1) <<< (shift - 5'd1))) >>> shift;
    end
    if (rnd > Y_MAX)      y = Y_MAX[OUT_W-1:0];
    else if (rnd < Y_MIN) y = Y_MIN[OUT_W-1:0];
    else                  y = rnd[OUT_W-1:0];
  end

endmodule

// File: rtl/dct2_1d_seq.sv
// Folded 1-D DCT-II: latches one vector, computes LANES rows per cycle, then holds the
// complete coefficient vector until downstream takes it.
module dct2_1d_seq
  import dct2_pkg::*;
#(
  parameter int MAX_N = 32,
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int LANES = 4,
  parameter int ACC_W = IN_W + 8 + $clog2(MAX_N) + 1
) (
  input  logic                clk,
  input  logic                rst,
  dct2_1d_seq_if.slave        bus,
  output state_e              state_dbg
);

  state_e                  state;
  state_e                  state_nx;
  logic [5:0]              row;
  logic [MAX_N*IN_W-1:0]   x_q;
  size_e                   size_q;
  logic [4:0]              shift_q;
  logic [MAX_N*OUT_W-1:0]  y_q;
  logic                    out_valid_q;
  logic                    last_row;

  logic [5:0]              lane_k [LANES];
  logic signed [OUT_W-1:0] lane_y [LANES];

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign lane_k[j] = row + 6'(j);
    dct2_lane #(
      .MAX_N (MAX_N),
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .size  (size_q),
      .k     (lane_k[j]),
      .shift (shift_q),
      .x     (x_q),
      .y     (lane_y[j])
    );
  end

  assign last_row      = (7'(row) + 7'(LANES)) >= 7'(size_of(size_q));
  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.Y         = y_q;
  assign state_dbg     = state;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (bus.in_valid) state_nx = ST_CALC;
      ST_CALC: if (last_row) state_nx = ST_DONE;
      ST_DONE: if (out_valid_q && bus.out_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      row         <= '0;
      x_q         <= '0;
      size_q      <= SZ4;
      shift_q     <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            x_q     <= bus.X;
            size_q  <= size_e'(bus.N);
            shift_q <= bus.shift;
            row     <= '0;
            y_q     <= '0;
          end
        end
        ST_CALC: begin
          // Lanes past the transform size leave their slots at zero.
          for (int j = 0; j < LANES; j++) begin
            if (int'(lane_k[j]) < size_of(size_q)) begin
              y_q[int'(lane_k[j])*OUT_W +: OUT_W] <= lane_y[j];
            end
          end
          row <= row + 6'(LANES);
        end
        ST_DONE: begin
          // out_valid rises one cycle after entering DONE and drops with the handshake.
          if (!out_valid_q)         out_valid_q <= 1'b1;
          else if (bus.out_ready)   out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
